// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the key event block.
//   - state_e       : FSM state encodings (IDLE, PRESSED, LONG)
//   - *_DEF         : default timing constants for the 50 MHz board clock
package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_e;

  localparam int unsigned CLK_HZ            = 32'd50_000_000;
  // 1 s hold before a long press, 200 ms between repeats at 50 MHz
  localparam int unsigned LONG_CYCLES_DEF   = 32'd50_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 32'd10_000_000;
  localparam int unsigned CNT_W_DEF         = 32'd26;

endpackage

// File: rtl/key_event_if.sv
// key_event_if: key level in, event strobes out.
//   key_xi     : debounced key level (driven by master)
//   press_xo   : one-cycle press strobe
//   release_xo : one-cycle release strobe
//   long_xo    : one-cycle long-press strobe
//   repeat_xo  : one-cycle auto-repeat strobe
//   held_xo    : key considered held (PRESSED or LONG)
interface key_event_if;

  logic key_xi;
  logic press_xo;
  logic release_xo;
  logic long_xo;
  logic repeat_xo;
  logic held_xo;

  modport master (
    output key_xi,
    input  press_xo, release_xo, long_xo, repeat_xo, held_xo
  );

  modport slave (
    input  key_xi,
    output press_xo, release_xo, long_xo, repeat_xo, held_xo
  );

endinterface

// File: rtl/key_sync.sv
// key_sync: brings the asynchronous key level into the clk domain and
// decodes its edges.
//   clk, rst : system clock, asynchronous active-high reset
//   i_key    : asynchronous key level
//   o_rise   : synchronised level went 0 -> 1 (combinational from flops)
//   o_fall   : synchronised level went 1 -> 0 (combinational from flops)
module key_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Two-flop synchroniser (s1, s2) plus one history flop (s3) for edge decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_key;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/key_event.sv
// key_event: turns the debounced key level into single-cycle event strobes
// (press, release, long press, auto-repeat) plus a held level.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : key_event_if.slave (key_xi in; press/release/long/repeat/held out)
// Parameters: LONG_CYCLES (hold before long_xo), REPEAT_CYCLES (repeat
// period after long_xo), CNT_W (counter width; both cycle counts must fit).
module key_event
  import key_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  key_event_if.slave  bus
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 32'd1);

  logic w_rise;
  logic w_fall;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             r_release;
  logic             r_long;
  logic             r_repeat;
  logic             r_held;

  key_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_key  (bus.key_xi),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Event FSM with hold/repeat counter; every output is a flop.
  // A fall is checked before any terminal count so release always wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= {CNT_W{1'b0}};
          if (w_rise) begin
            r_state <= ST_PRESSED;
            r_press <= 1'b1;
            r_held  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_held  <= 1'b0;
          end
        end
        ST_PRESSED: begin
          if (w_fall) begin
            r_state   <= ST_IDLE;
            r_release <= 1'b1;
            r_held    <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
          end else if (r_cnt == LONG_LAST) begin
            r_state <= ST_LONG;
            r_long  <= 1'b1;
            r_held  <= 1'b1;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_state <= ST_PRESSED;
            r_held  <= 1'b1;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        ST_LONG: begin
          if (w_fall) begin
            r_state   <= ST_IDLE;
            r_release <= 1'b1;
            r_held    <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
          end else if (r_cnt == REPEAT_LAST) begin
            r_state  <= ST_LONG;
            r_repeat <= 1'b1;
            r_held   <= 1'b1;
            r_cnt    <= {CNT_W{1'b0}};
          end else begin
            r_state <= ST_LONG;
            r_held  <= 1'b1;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          // Unused encoding: recover to IDLE silently
          r_state <= ST_IDLE;
          r_held  <= 1'b0;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.press_xo   = r_press;
  assign bus.release_xo = r_release;
  assign bus.long_xo    = r_long;
  assign bus.repeat_xo  = r_repeat;
  assign bus.held_xo    = r_held;

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed scenarios plus random key waveforms for key_event,
// checked every cycle against a hold-duration reference model.
module tb_key_event;
  import key_pkg::*;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_event_if bus();

  key_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference model: the key as seen by the event logic lags two edges
  // behind the sampled pin; events follow from how long it has been held.
  bit d0, d1, d2, d3;
  bit m_held;
  int m_age;
  bit e_press, e_rel, e_long, e_rep;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int long_at, rep_at, press_at;
  int long_n, rep_n, rel_n, press_n;

  task automatic model_reset();
    d0 = 1'b0; d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
    m_held = 1'b0; m_age = 0;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
  endtask

  task automatic model_edge(input bit v);
    d3 = d2; d2 = d1; d1 = d0; d0 = v;
    e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0; e_rep = 1'b0;
    if (m_held && !d2 && d3) begin
      e_rel  = 1'b1;
      m_held = 1'b0;
    end else if (m_held) begin
      m_age++;
      if (m_age == L) e_long = 1'b1;
      else if (m_age > L && ((m_age - L) % R) == 0) e_rep = 1'b1;
    end else if (d2 && !d3) begin
      e_press = 1'b1;
      m_held  = 1'b1;
      m_age   = 0;
    end
  endtask

  task automatic chk(input string tag, input logic a, input logic e);
    n_checks++;
    assert (a === e) else begin
      n_errors++;
      $error("FAIL %s at cyc %0d: observed %b expected %b", tag, cyc, a, e);
    end
  endtask

  task automatic chk_int(input string tag, input int a, input int e);
    n_checks++;
    assert (a === e) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, a, e);
    end
  endtask

  task automatic check_all();
    chk("press",   bus.press_xo,   e_press);
    chk("release", bus.release_xo, e_rel);
    chk("long",    bus.long_xo,    e_long);
    chk("repeat",  bus.repeat_xo,  e_rep);
    chk("held",    bus.held_xo,    m_held);
  endtask

  task automatic clr_stats();
    cyc = 0; long_at = -1; rep_at = -1; press_at = -1;
    long_n = 0; rep_n = 0; rel_n = 0; press_n = 0;
  endtask

  // One clk cycle: drive the level, let it be sampled, then compare.
  task automatic step(input bit v);
    bus.key_xi = v;
    @(posedge clk);
    model_edge(v);
    #1;
    check_all();
    if (bus.long_xo === 1'b1) begin long_n++; if (long_at < 0) long_at = cyc; end
    if (bus.repeat_xo === 1'b1) begin rep_n++; if (rep_at < 0) rep_at = cyc; end
    if (bus.press_xo === 1'b1) begin press_n++; if (press_at < 0) press_at = cyc; end
    if (bus.release_xo === 1'b1) rel_n++;
    cyc++;
  endtask

  initial begin
    bus.key_xi = 1'b0;
    model_reset();
    clr_stats();

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Short press: 5 high, then low
    clr_stats();
    repeat (5) step(1'b1);
    repeat (10) step(1'b0);
    chk_int("short_press_edge", press_at, 2);
    chk_int("short_long_count", long_n, 0);
    chk_int("short_release_count", rel_n, 1);

    // Long hold: 30 high
    clr_stats();
    repeat (30) step(1'b1);
    repeat (6) step(1'b0);
    chk_int("long_edge", long_at, 2 + L);
    chk_int("first_repeat_edge", rep_at, 2 + L + R);
    chk_int("repeat_count", rep_n, 5);
    chk_int("long_release_count", rel_n, 1);

    // Collision: fall seen while cnt is at its terminal value
    clr_stats();
    repeat (L) step(1'b1);
    repeat (8) step(1'b0);
    chk_int("collision_long_count", long_n, 0);
    chk_int("collision_release_count", rel_n, 1);

    // Reset mid-hold while in LONG, key stays high
    clr_stats();
    repeat (14) step(1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    clr_stats();
    repeat (6) step(1'b1);
    chk_int("press_after_reset_edge", press_at, 2);
    repeat (6) step(1'b0);
    chk_int("reset_release_count", rel_n, 1);

    // Glitch then idle
    clr_stats();
    step(1'b1);
    repeat (20) step(1'b0);
    chk_int("glitch_long_count", long_n, 0);
    chk_int("glitch_repeat_count", rep_n, 0);
    chk_int("glitch_press_release", press_n, rel_n);

    // Illegal state encoding
    force dut.r_state = state_e'(2'b11);
    #1;
    release dut.r_state;
    step(1'b0);
    chk_int("illegal_state_recovery", int'(dut.r_state), int'(ST_IDLE));
    repeat (3) step(1'b0);

    // Random key waveforms
    clr_stats();
    for (int run = 0; run < 40; run++) begin
      int hi_len;
      int lo_len;
      hi_len = $urandom_range(1, 30);
      lo_len = $urandom_range(1, 12);
      repeat (hi_len) step(1'b1);
      repeat (lo_len) step(1'b0);
    end
    repeat (4) step(1'b0);
    chk_int("random_press_release_balance", press_n, rel_n);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_event.md
# key_event

Converts the debounced key level from the debounce stage into one-cycle event pulses in the system clock domain:
- press and release pulses;
- a long-press pulse after a hold threshold;
- auto-repeat pulses while the key stays held.

It sits directly downstream of the debouncer and feeds the CPU front panel (single-step, mode select), so that consumers see clean single-cycle strobes instead of a slow level.

## Interface
Parameters:
- LONG_CYCLES, default 50_000_000 — hold time in clk cycles before long_xo fires; legal range 2 .. 2^CNT_W−1.
- REPEAT_CYCLES, default 10_000_000 — auto-repeat period in clk cycles; legal range 2 .. 2^CNT_W−1.
- CNT_W, default 26 — width of the hold/repeat counter.

Ports:
- clk  in  1  system clock; every flop is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_xi  in  1  debounced key level from the debounce stage; asynchronous to clk.
- press_xo  out  1  one-cycle pulse on a press.
- release_xo  out  1  one-cycle pulse on a release.
- long_xo  out  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- repeat_xo  out  1  one-cycle pulse every REPEAT_CYCLES after long_xo, while the key is held.
- held_xo  out  1  high while the FSM is in PRESSED or LONG.

## Operation
Input synchronisation:
- key_xi passes through two flops, s1 and s2.
- s3 holds the previous value of s2.
- rise = s2 & ~s3; fall = ~s2 & s3.

FSM states:
- IDLE
  - rise → PRESSED; press_xo=1; cnt cleared to 0.
- PRESSED
  - fall → IDLE; release_xo=1; cnt cleared.
  - cnt==LONG_CYCLES−1 → LONG; long_xo=1; cnt cleared.
  - Otherwise cnt+1.
- LONG
  - fall → IDLE; release_xo=1; cnt cleared.
  - cnt==REPEAT_CYCLES−1 → repeat_xo=1; cnt cleared; stay in LONG.
  - Otherwise cnt+1.
- Undefined encodings → IDLE with all outputs 0.

Output rules:
- All outputs are registered.
- At most one event pulse is high in any cycle.
- held_xo=1 exactly in PRESSED and LONG.

Boundary conditions:
- fall in the same cycle as a terminal count: fall wins. release_xo only; no long_xo or repeat_xo.
- Key high through reset: after rst deasserts, s2 fills to 1 while s3 is still 0, so a press is reported. This is intended.
- rst mid-hold: everything clears immediately, with no release pulse. Behaviour after deassert follows the rule above.
- Glitch on key_xi shorter than one clk period: may be missed. The debouncer output is slow, so this is acceptable.
- cnt never wraps; terminal compares bound it.

## Timing
Reset values:
- state IDLE; cnt 0; s1, s2, s3 0.
- press_xo, release_xo, long_xo, repeat_xo, held_xo all 0.

Latencies (edge 0 is the first clk edge at which key_xi is sampled at its new level):
- Press: press_xo and held_xo go high after edge 2. press_xo drops after edge 3.
- Release: release_xo high after edge 2; held_xo low after edge 2.
- long_xo: high after edge 2+LONG_CYCLES, counted from the press edge 0.
- First repeat_xo: after edge 2+LONG_CYCLES+REPEAT_CYCLES. Further repeats follow every REPEAT_CYCLES.
- Events require key_xi to stay stable for at least 2 clk cycles.

## Structure
- Shared package key_pkg holds:
  - state encodings (IDLE=2'd0, PRESSED=2'd1, LONG=2'd2);
  - default cycle constants for the 50 MHz board clock.
- One sub-module, key_sync: the 2-flop synchroniser plus s3 and the rise/fall decode.
- The FSM and counter live in key_event.

## Test plan
All scenarios use LONG_CYCLES=8 and REPEAT_CYCLES=4.
- Short press: key_xi high for 5 cycles, then low.
  - press_xo 1 cycle after edge 2.
  - release_xo 1 cycle at 2 edges after the fall.
  - No long_xo.
- Long hold: key_xi high for 30 cycles.
  - long_xo after edge 10.
  - repeat_xo after edges 14, 18, 22, 26, 30.
  - release_xo after the fall; held_xo high throughout the hold.
- Collision: time the release so that the fall is seen in the same cycle as cnt==7.
  - release_xo only; long_xo never asserts.
- Reset mid-hold: assert rst during LONG.
  - All outputs 0 in the same cycle, no release_xo.
  - With key_xi held, press_xo appears 3 edges after deassert.
- Glitch and idle: one-cycle key_xi pulse, then 20 cycles low.
  - Either no events, or a press immediately followed by a release.
  - Never long_xo or repeat_xo.
- Illegal state: force state=2'd3.
  - Returns to IDLE on the next edge; all outputs 0.
